// File: rtl/tile_pixel_serializer_pkg.sv
// Shared constants and helpers for the tile pixel serializer.
// It holds the default widths, the tile geometry, and a small predicate
// on the pixel counter.
package tile_pixel_serializer_pkg;

  // Default parameter values of the top-level block.
  localparam int TILE_TYPE_WIDTH_DEF = 7;
  localparam int ROM_ADDR_WIDTH_DEF  = 12;
  localparam int ROM_DATA_WIDTH_DEF  = 96;
  localparam int SELECT_SIZE_DEF     = 3;

  // Tile geometry: 32 pixels per row, so a row index needs 5 bits.
  localparam int PIXELS_PER_ROW = 32;
  localparam int TILE_ROW_BITS  = 5;

  // Index of the final pixel in a row word.
  localparam logic [TILE_ROW_BITS-1:0] LAST_PIXEL = TILE_ROW_BITS'(PIXELS_PER_ROW - 1);

  // True when the pixel counter points at the final pixel of the word.
  function automatic logic is_last_pixel(input logic [TILE_ROW_BITS-1:0] cnt);
    return (cnt == LAST_PIXEL);
  endfunction

endpackage

// File: rtl/tile_pixel_serializer_pixel_shift_serializer.sv
// Row-word serializer. It loads one ROM row word and then emits it one
// pixel per clock, most significant pixel first. It asks for the next word
// while it shows the last pixel, so that consecutive words stream without
// a gap.
module pixel_shift_serializer
  import tile_pixel_serializer_pkg::*;
#(
  parameter int DATA_WIDTH  = ROM_DATA_WIDTH_DEF,
  parameter int SELECT_SIZE = SELECT_SIZE_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_WIDTH-1:0]  rom_data_i,
  output logic                   ready_read_o,
  output logic [SELECT_SIZE-1:0] serial_data_o,
  output logic                   pixel_valid_o
);

  logic [DATA_WIDTH-1:0]    r_shift;
  logic [TILE_ROW_BITS-1:0] r_cnt;
  logic                     r_loaded;
  logic [SELECT_SIZE-1:0]   r_serial;
  logic                     r_valid;
  logic                     w_ready;

  // Load request: the register is empty, or its last pixel is on the output.
  always_comb begin
    w_ready = 1'b0;
    if (!r_loaded) begin
      w_ready = 1'b1;
    end else if (is_last_pixel(r_cnt)) begin
      w_ready = 1'b1;
    end else begin
      w_ready = 1'b0;
    end
  end

  // Shift register, pixel counter, loaded flag and the registered outputs.
  // The counter returns to zero only through a load.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_loaded <= 1'b0;
      r_serial <= '0;
      r_valid  <= 1'b0;
    end else if (w_ready) begin
      // Pixel 0 goes straight to the output; the rest stays queued.
      r_shift  <= rom_data_i << SELECT_SIZE;
      r_serial <= rom_data_i[DATA_WIDTH-1 -: SELECT_SIZE];
      r_cnt    <= '0;
      r_loaded <= 1'b1;
      r_valid  <= 1'b1;
    end else begin
      r_serial <= r_shift[DATA_WIDTH-1 -: SELECT_SIZE];
      r_shift  <= r_shift << SELECT_SIZE;
      r_cnt    <= r_cnt + 5'd1;
      r_loaded <= r_loaded;
      r_valid  <= r_valid;
    end
  end

  assign ready_read_o  = w_ready;
  assign serial_data_o = r_serial;
  assign pixel_valid_o = r_valid;

endmodule

// File: rtl/tile_pixel_serializer.sv
// Tile pixel serializer top level. It forms the pixel-ROM address from the
// tile code and the row within the tile. A sub-module turns the returned
// row word into a pixel stream.
module tile_pixel_serializer
  import tile_pixel_serializer_pkg::*;
#(
  parameter int TILE_TYPE_WIDTH = TILE_TYPE_WIDTH_DEF,
  parameter int ROM_ADDR_WIDTH  = ROM_ADDR_WIDTH_DEF,   // must be TILE_TYPE_WIDTH + 5
  parameter int ROM_DATA_WIDTH  = ROM_DATA_WIDTH_DEF,   // must be 32 * SELECT_SIZE
  parameter int SELECT_SIZE     = SELECT_SIZE_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [TILE_TYPE_WIDTH-1:0] tile_type_i,
  input  logic [TILE_ROW_BITS-1:0]   v_cntr_mod32_i,
  input  logic [ROM_DATA_WIDTH-1:0]  rom_data_i,
  output logic [ROM_ADDR_WIDTH-1:0]  pixel_addr_o,
  output logic                       ready_read_o,
  output logic [SELECT_SIZE-1:0]     serial_data_o,
  output logic                       pixel_valid_o
);

  logic [ROM_ADDR_WIDTH-1:0] w_pixel_addr;

  // ROM address = tile_type * 32 + row. It is held at zero while in reset.
  always_comb begin
    w_pixel_addr = '0;
    if (!rst_i) begin
      w_pixel_addr = '0;
    end else begin
      w_pixel_addr = ROM_ADDR_WIDTH'({tile_type_i, v_cntr_mod32_i});
    end
  end

  assign pixel_addr_o = w_pixel_addr;

  pixel_shift_serializer #(
    .DATA_WIDTH  (ROM_DATA_WIDTH),
    .SELECT_SIZE (SELECT_SIZE)
  ) u_pixel_shift_serializer (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .rom_data_i    (rom_data_i),
    .ready_read_o  (ready_read_o),
    .serial_data_o (serial_data_o),
    .pixel_valid_o (pixel_valid_o)
  );

endmodule

// File: tb/tb_tile_pixel_serializer.sv
// Directed self-checking bench for tile_pixel_serializer.
module tb_tile_pixel_serializer;

  logic        clk_i;
  logic        rst_i;
  logic [6:0]  tile_type_i;
  logic [4:0]  v_cntr_mod32_i;
  logic [95:0] rom_data_i;
  logic [11:0] pixel_addr_o;
  logic        ready_read_o;
  logic [2:0]  serial_data_o;
  logic        pixel_valid_o;

  int n_cmp;
  int n_err;

  // Pixel 0 is in the top three bits of each word.
  localparam logic [95:0] WORD_A = 96'h924924924924924924924924; // every pixel 3'b100
  localparam logic [95:0] WORD_B = 96'h053977053977053977053977; // pixel k = k mod 8
  localparam logic [95:0] WORD_C = 96'h6DB6DB6DB6DB6DB6DB6DB6DB; // every pixel 3'b011
  localparam logic [95:0] JUNK   = 96'hFFFFFFFFFFFFFFFFFFFFFFFF;

  tile_pixel_serializer dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .tile_type_i    (tile_type_i),
    .v_cntr_mod32_i (v_cntr_mod32_i),
    .rom_data_i     (rom_data_i),
    .pixel_addr_o   (pixel_addr_o),
    .ready_read_o   (ready_read_o),
    .serial_data_o  (serial_data_o),
    .pixel_valid_o  (pixel_valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_i = 1'b0;
    tile_type_i = 7'd5;
    v_cntr_mod32_i = 5'd3;
    rom_data_i = WORD_A;

    // Reset state
    #2;
    chk("rst_addr", 96'(pixel_addr_o), 96'd0);
    chk("rst_serial", 96'(serial_data_o), 96'd0);
    chk("rst_valid", 96'(pixel_valid_o), 96'd0);
    chk("rst_ready", 96'(ready_read_o), 96'd1);

    // Release reset; check the address mapping
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("addr_5_3", 96'(pixel_addr_o), 96'd163);
    tile_type_i = 7'd127;
    v_cntr_mod32_i = 5'd31;
    #1;
    chk("addr_127_31", 96'(pixel_addr_o), 96'd4095);
    chk("ready_before_load", 96'(ready_read_o), 96'd1);

    // Word A: pixel 0 appears one edge after load; rom changes are ignored mid-word
    @(negedge clk_i);
    chk("a_first_pixel", 96'(serial_data_o), 96'd4);
    chk("a_first_valid", 96'(pixel_valid_o), 96'd1);
    rom_data_i = JUNK;
    for (int k = 0; k < 31; k++) begin
      chk("a_ready_low", 96'(ready_read_o), 96'd0);
      chk("a_pixel", 96'(serial_data_o), 96'd4);
      @(negedge clk_i);
    end
    // Pixel 31 of A is now on the output
    chk("a_last_pixel", 96'(serial_data_o), 96'd4);
    chk("a_ready_at_31", 96'(ready_read_o), 96'd1);
    rom_data_i = WORD_B;

    // Word B follows with no gap
    for (int k = 0; k < 32; k++) begin
      @(negedge clk_i);
      if (k == 0) rom_data_i = JUNK;
      chk("b_pixel", 96'(serial_data_o), 96'(k % 8));
      chk("b_valid", 96'(pixel_valid_o), 96'd1);
      chk("b_ready", 96'(ready_read_o), (k == 31) ? 96'd1 : 96'd0);
    end
    rom_data_i = WORD_C;

    // Word C: pull reset at pixel 10
    for (int k = 0; k < 11; k++) begin
      @(negedge clk_i);
      if (k == 0) rom_data_i = JUNK;
    end
    chk("c_pixel10", 96'(serial_data_o), 96'd3);
    rst_i = 1'b0;
    #1;
    chk("midrst_serial", 96'(serial_data_o), 96'd0);
    chk("midrst_valid", 96'(pixel_valid_o), 96'd0);
    chk("midrst_ready", 96'(ready_read_o), 96'd1);
    chk("midrst_addr", 96'(pixel_addr_o), 96'd0);
    @(negedge clk_i);
    chk("held_serial", 96'(serial_data_o), 96'd0);
    rst_i = 1'b1;
    rom_data_i = WORD_B;

    // After release a fresh word starts at pixel 0
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      if (k == 0) rom_data_i = JUNK;
      chk("post_rst_pixel", 96'(serial_data_o), 96'(k));
      chk("post_rst_valid", 96'(pixel_valid_o), 96'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
